// File: rtl/time_display_pkg.sv
// Shared constants for the multiplexed 7-segment time display.
//   DIGIT_W / SEG_W : nibble and segment-bus widths
//   NUM_DIGITS      : digits on the display (scan slots per frame)
//   SEG_*           : active-low {g,f,e,d,c,b,a} codes
//   IDX_*           : scan index of each digit (0 = rightmost)
package time_display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] IDX_MIN_ONES = 2'd0;
    localparam logic [1:0] IDX_MIN_TENS = 2'd1;
    localparam logic [1:0] IDX_HR_ONES  = 2'd2;
    localparam logic [1:0] IDX_HR_TENS  = 2'd3;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   bcd : 4-bit digit; values above 9 show a dash
//   seg : active-low {g,f,e,d,c,b,a}
module bcd_to_seven_seg
    import time_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// Drives a 4-digit multiplexed common-anode 7-segment display from BCD time.
// One digit per slot; the time is snapshotted at the start of each frame so a
// frame never mixes old and new values.
//   i_Clk_5MHz      : clock
//   i_Reset         : synchronous, active-high reset
//   i_Clk_1Hz_Pulse : each rising edge toggles the blink phase
//   i_Time          : BCD {hrs tens, hrs ones, min tens, min ones}
//   i_PM            : PM indicator (dot on rightmost digit)
//   i_Blink_Hours   : blink hour digits
//   i_Blink_Minutes : blink minute digits
//   o_Anodes        : active-low digit enables, bit0 = rightmost
//   o_Segments      : active-low {g,f,e,d,c,b,a}
//   o_DP            : active-low decimal point of the enabled digit
module time_display_scan
    import time_display_pkg::*;
#(
    parameter int CLKS_PER_DIGIT = 5000,
    parameter int BLANK_CLKS     = 250
) (
    input  logic                  i_Clk_5MHz,
    input  logic                  i_Reset,
    input  logic                  i_Clk_1Hz_Pulse,
    input  logic [15:0]           i_Time,
    input  logic                  i_PM,
    input  logic                  i_Blink_Hours,
    input  logic                  i_Blink_Minutes,
    output logic [NUM_DIGITS-1:0] o_Anodes,
    output logic [SEG_W-1:0]      o_Segments,
    output logic                  o_DP
);

    localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CLKS);

    logic [CNT_W-1:0]                         cnt;
    logic [1:0]                               idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       snap;
    logic                                     phase;
    logic                                     pulse_d;

    logic [NUM_DIGITS-1:0][SEG_W-1:0]         dig_seg;
    logic [NUM_DIGITS-1:0]                    anodes_nxt;
    logic [SEG_W-1:0]                         seg_nxt;
    logic                                     dp_nxt;
    logic                                     blink_field;

    // One decoder per digit; the scan mux below picks the active one.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_to_seven_seg u_dec (
            .bcd (snap[g]),
            .seg (dig_seg[g])
        );
    end

    always_comb begin
        anodes_nxt  = '1;
        seg_nxt     = dig_seg[idx];
        dp_nxt      = 1'b1;
        // idx[1] separates hour digits (2,3) from minute digits (0,1).
        blink_field = idx[1] ? i_Blink_Hours : i_Blink_Minutes;

        if (idx == IDX_HR_TENS && snap[idx] == '0)
            seg_nxt = SEG_BLANK;
        if (blink_field && !phase)
            seg_nxt = SEG_BLANK;

        // Dots are deliberately left out of blinking.
        case (idx)
            IDX_MIN_ONES: dp_nxt = ~i_PM;
            IDX_HR_ONES:  dp_nxt = ~phase;
            default:      dp_nxt = 1'b1;
        endcase

        // Anti-ghosting: all anodes off for the first part of every slot.
        if (cnt < CNT_BLANK) begin
            seg_nxt = SEG_BLANK;
            dp_nxt  = 1'b1;
        end else begin
            anodes_nxt = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            phase      <= 1'b1;
            pulse_d    <= 1'b0;
            o_Anodes   <= '1;
            o_Segments <= SEG_BLANK;
            o_DP       <= 1'b1;
        end else begin
            pulse_d <= i_Clk_1Hz_Pulse;
            if (i_Clk_1Hz_Pulse && !pulse_d)
                phase <= ~phase;

            if (cnt == '0 && idx == IDX_MIN_ONES)
                snap <= i_Time;

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            o_Anodes   <= anodes_nxt;
            o_Segments <= seg_nxt;
            o_DP       <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
module tb_time_display_scan;

    localparam int CPD = 4;
    localparam int BLK = 1;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        pulse = 1'b0;
    logic        pm    = 1'b0;
    logic        bh    = 1'b0;
    logic        bm    = 1'b0;
    logic [15:0] tm    = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    time_display_scan #(.CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BLK)) dut (
        .i_Clk_5MHz      (clk),
        .i_Reset         (rst),
        .i_Clk_1Hz_Pulse (pulse),
        .i_Time          (tm),
        .i_PM            (pm),
        .i_Blink_Hours   (bh),
        .i_Blink_Minutes (bm),
        .o_Anodes        (an),
        .o_Segments      (seg),
        .o_DP            (dp)
    );

    task automatic push1(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_frame(input string tag,
                              input logic [6:0] s0, input logic d0,
                              input logic [6:0] s1, input logic d1,
                              input logic [6:0] s2, input logic d2,
                              input logic [6:0] s3, input logic d3);
        push1({tag, "_idx0"}, 4'b1110, s0, d0);
        push1({tag, "_idx1"}, 4'b1101, s1, d1);
        push1({tag, "_idx2"}, 4'b1011, s2, d2);
        push1({tag, "_idx3"}, 4'b0111, s3, d3);
    endtask

    // Wait (bounded) until at most 'left' expectations remain; returns at a negedge.
    task automatic wait_q(input int left, input string tag);
        int n;
        n = 0;
        while (q.size() > left && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() > left) begin
            failures++;
            $display("FAIL %s_timeout: %0d pending, required %0d", tag, q.size(), left);
            q.delete();
        end
    endtask

    // Called at a negedge; holds reset for one edge and checks the reset outputs.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL %s_reset: an=%b seg=%h dp=%b, required an=1111 seg=7f dp=1", tag, an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic one_pulse(input int cycles);
        pulse = 1'b1;
        repeat (cycles) @(negedge clk);
        pulse = 1'b0;
    endtask

    // Monitor: checks blank cycles, slot length, and pops one expectation per displayed slot.
    initial begin : mon
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                run = 0;
            end else if (an === 4'hF) begin
                checks++;
                if (seg !== 7'h7F || dp !== 1'b1) begin
                    failures++;
                    $display("FAIL blank_cycle: seg=%h dp=%b, required seg=7f dp=1", seg, dp);
                end
                if (run != 0) begin
                    checks++;
                    if (run != CPD - BLK) begin
                        failures++;
                        $display("FAIL slot_length: %0d cycles, required %0d", run, CPD - BLK);
                    end
                end
                run = 0;
            end else begin
                if (run == 0 && q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                        failures++;
                        $display("FAIL %s: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                                 e.tag, an, seg, dp, e.an, e.seg, e.dp);
                    end
                end
                run++;
            end
        end
    end

    initial begin
        @(negedge clk);

        // Basic scan, PM dot, colon follows phase.
        tm = 16'h1245; pm = 1'b1;
        do_reset("t1");
        push_frame("t1f1", 7'h12, 1'b0, 7'h19, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        push_frame("t1f2", 7'h12, 1'b0, 7'h19, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        wait_q(0, "t1a");
        push_frame("t1f3", 7'h12, 1'b1, 7'h19, 1'b1, 7'h24, 1'b1, 7'h79, 1'b1);
        pm = 1'b0;
        one_pulse(1);
        wait_q(0, "t1b");

        // Leading-zero blanking.
        tm = 16'h0930; pm = 1'b0;
        do_reset("t2");
        push_frame("t2", 7'h40, 1'b1, 7'h30, 1'b1, 7'h10, 1'b0, 7'h7F, 1'b1);
        wait_q(0, "t2");

        // Mid-frame time change is held off until the next frame.
        tm = 16'h1159; pm = 1'b0;
        do_reset("t3");
        push_frame("t3old", 7'h10, 1'b1, 7'h12, 1'b1, 7'h79, 1'b0, 7'h79, 1'b1);
        push_frame("t3new", 7'h40, 1'b1, 7'h40, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        wait_q(5, "t3a");
        tm = 16'h1200;
        wait_q(0, "t3b");

        // Minute blinking with a multi-cycle pulse (toggles once).
        tm = 16'h1245; pm = 1'b0; bm = 1'b1;
        do_reset("t4");
        push_frame("t4on", 7'h12, 1'b1, 7'h19, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        wait_q(0, "t4a");
        push_frame("t4off", 7'h7F, 1'b1, 7'h7F, 1'b1, 7'h24, 1'b1, 7'h79, 1'b1);
        one_pulse(4);
        wait_q(0, "t4b");
        push_frame("t4back", 7'h12, 1'b1, 7'h19, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        one_pulse(1);
        wait_q(0, "t4c");
        bm = 1'b0;

        // Non-BCD nibbles show a dash.
        tm = 16'h1A3F; pm = 1'b1;
        do_reset("t5");
        push_frame("t5", 7'h3F, 1'b0, 7'h30, 1'b1, 7'h3F, 1'b0, 7'h79, 1'b1);
        wait_q(0, "t5");

        // Reset during idx2 restores phase and restarts with a fresh snapshot.
        tm = 16'h1245; pm = 1'b1;
        do_reset("t6");
        push_frame("t6a", 7'h12, 1'b0, 7'h19, 1'b1, 7'h24, 1'b0, 7'h79, 1'b1);
        wait_q(0, "t6a");
        push1("t6b_idx0", 4'b1110, 7'h12, 1'b0);
        push1("t6b_idx1", 4'b1101, 7'h19, 1'b1);
        push1("t6b_idx2", 4'b1011, 7'h24, 1'b1);
        one_pulse(1);
        wait_q(0, "t6b");
        tm = 16'h0930;
        do_reset("t6mid");
        push_frame("t6c", 7'h40, 1'b0, 7'h30, 1'b1, 7'h10, 1'b0, 7'h7F, 1'b1);
        wait_q(0, "t6c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
